// File: rtl/timer_pkg.sv
// Shared definitions for the seconds-based timer family: the delay timer
// and its counterpart, the pulse width meter.
//
// Contents:
//   CLK_CYCLES_PER_SECOND_DEF  default clock cycles per second (simulation value)
//   SEC_W_DEF                  default width of a seconds value
//   SYNC_STAGES_DEF            default synchroniser depth for asynchronous inputs
//   meter_state_t              pulse width meter FSM states
package timer_pkg;

    localparam int CLK_CYCLES_PER_SECOND_DEF = 10;
    localparam int SEC_W_DEF                 = 5;
    localparam int SYNC_STAGES_DEF           = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOW  = 2'd1,
        WAIT_RISE = 2'd2,
        MEASURE   = 2'd3
    } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level signal into the clk domain and flags its
// edges.
//
// Ports:
//   clk     in   clock, all logic on posedge
//   rst     in   asynchronous, active-high reset; clears every flop to 0
//   sig_in  in   asynchronous level input
//   sig_s   out  synchronised level (last synchroniser stage)
//   rise    out  sig_s went 0->1 this cycle
//   fall    out  sig_s went 1->0 this cycle
//
// SYNC_STAGES must be at least 2.
module sync_edge_detect #(
    parameter int SYNC_STAGES = timer_pkg::SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sig_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            sig_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d;
    assign fall  = ~sig_s & sig_d;

endmodule

// File: rtl/pulse_width_meter.sv
// One-shot pulse width meter: after an arm request, measures the next
// complete high pulse on sig_in and reports its length in whole seconds.
//
// Ports:
//   clk       in   clock, all logic on posedge
//   rst       in   asynchronous, active-high reset
//   arm       in   1-cycle request to capture the next complete high pulse
//   sig_in    in   measured signal, asynchronous to clk
//   busy      out  armed or measuring
//   seconds   out  last measured width in seconds, held until next result
//   overflow  out  last result saturated
//   valid     out  1-cycle strobe: seconds/overflow just updated
//
// Build option PULSE_METER_ROUND_EN: round the result half-up using the
// leftover sub-second cycle count instead of truncating it.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | not armed; arm selects WAIT_LOW or WAIT_RISE
// WAIT_LOW  | armed while the input was already high; skip that pulse
// WAIT_RISE | armed, waiting for the leading edge of the pulse to measure
// MEASURE   | counting high cycles; trailing edge publishes the result
module pulse_width_meter
    import timer_pkg::*;
#(
    parameter int CLK_CYCLES_PER_SECOND = timer_pkg::CLK_CYCLES_PER_SECOND_DEF,
    parameter int SEC_W                 = timer_pkg::SEC_W_DEF,
    parameter int SYNC_STAGES           = timer_pkg::SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             sig_in,
    output logic             busy,
    output logic [SEC_W-1:0] seconds,
    output logic             overflow,
    output logic             valid
);

    localparam int               CPS      = CLK_CYCLES_PER_SECOND;
    localparam int               CYC_W    = $clog2(CPS);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CPS - 1);
    localparam logic [SEC_W-1:0] SEC_MAX  = {SEC_W{1'b1}};
`ifdef PULSE_METER_ROUND_EN
    localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(CPS / 2);
`endif

    logic sig_s;
    logic rise;
    logic fall;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .sig_in(sig_in),
        .sig_s (sig_s),
        .rise  (rise),
        .fall  (fall)
    );

    meter_state_t     state, state_nxt;
    logic [CYC_W-1:0] cyc_cnt, cyc_nxt;
    logic [SEC_W-1:0] sec_cnt, sec_nxt;
    logic             ovf_flag, ovf_nxt;
    logic             load_result;
    logic [SEC_W-1:0] result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cyc_cnt  <= '0;
            sec_cnt  <= '0;
            ovf_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            cyc_cnt  <= cyc_nxt;
            sec_cnt  <= sec_nxt;
            ovf_flag <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cyc_nxt     = cyc_cnt;
        sec_nxt     = sec_cnt;
        ovf_nxt     = ovf_flag;
        load_result = 1'b0;

        case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt = sig_s ? WAIT_LOW : WAIT_RISE;
                end
            end

            WAIT_LOW: begin
                if (fall) begin
                    state_nxt = WAIT_RISE;
                end
            end

            WAIT_RISE: begin
                // The rise cycle is itself the first high cycle.
                if (rise) begin
                    state_nxt = MEASURE;
                    cyc_nxt   = CYC_W'(1);
                    sec_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            end

            MEASURE: begin
                if (fall) begin
                    state_nxt   = IDLE;
                    load_result = 1'b1;
                end else if (sig_s) begin
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_nxt = '0;
                        // Seconds stick at full scale; remember that a
                        // carry was lost so the result is flagged.
                        if (sec_cnt == SEC_MAX) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            sec_nxt = sec_cnt + SEC_W'(1);
                        end
                    end else begin
                        cyc_nxt = cyc_cnt + CYC_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Rounding never sets overflow; it only saturates at full scale.
    always_comb begin
        result = sec_cnt;
`ifdef PULSE_METER_ROUND_EN
        if ((cyc_cnt >= CYC_HALF) && (sec_cnt != SEC_MAX)) begin
            result = sec_cnt + SEC_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seconds  <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= load_result;
            if (load_result) begin
                seconds  <= result;
                overflow <= ovf_flag;
            end
        end
    end

    // Registered state means busy drops in the same cycle valid rises.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_width_meter.sv
module tb_pulse_width_meter;

    localparam int CPS     = 10;
    localparam int SEC_W   = 5;
    localparam int SEC_TOP = (1 << SEC_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             arm = 1'b0;
    logic             sig_in = 1'b0;
    logic             busy;
    logic [SEC_W-1:0] seconds;
    logic             overflow;
    logic             valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [SEC_W-1:0] last_sec = '0;
    logic             last_ovf = 1'b0;

    pulse_width_meter #(
        .CLK_CYCLES_PER_SECOND(CPS),
        .SEC_W                (SEC_W),
        .SYNC_STAGES          (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .arm     (arm),
        .sig_in  (sig_in),
        .busy    (busy),
        .seconds (seconds),
        .overflow(overflow),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    // Reference: width in whole seconds from the count of high cycles.
    function automatic logic [SEC_W:0] model(input int h);
        int  s;
        logic o;
        s = h / CPS;
        o = (h >= (SEC_TOP + 1) * CPS);
`ifdef PULSE_METER_ROUND_EN
        if ((h % CPS) >= CPS / 2) s = s + 1;
`endif
        if (s > SEC_TOP) s = SEC_TOP;
        return {o, SEC_W'(s)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Drive a pulse of h cycles then watch for the result.
    task automatic run_pulse(input int h, output int vcnt,
                             output logic [SEC_W-1:0] s, output logic o);
        vcnt = 0;
        s    = seconds;
        o    = overflow;
        sig_in = 1'b1;
        repeat (h) tick();
        sig_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid) begin
                vcnt++;
                s = seconds;
                o = overflow;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (seconds !== '0) begin n_fail++; $display("FAIL reset_seconds got=%0d exp=0", seconds); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_directed();
        int               widths[4] = '{30, 39, 400, 20};
        int               vcnt;
        logic [SEC_W-1:0] s;
        logic             o;
        logic [SEC_W:0]   e;
        foreach (widths[k]) begin
            do_arm();
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dir_busy_armed w=%0d got=%b exp=1", widths[k], busy); end
            repeat (2) tick();
            run_pulse(widths[k], vcnt, s, o);
            e = model(widths[k]);
            n_checks++; if (vcnt !== 1) begin n_fail++; $display("FAIL dir_valid_count w=%0d got=%0d exp=1", widths[k], vcnt); end
            n_checks++; if (s !== e[SEC_W-1:0]) begin n_fail++; $display("FAIL dir_seconds w=%0d got=%0d exp=%0d", widths[k], s, e[SEC_W-1:0]); end
            n_checks++; if (o !== e[SEC_W]) begin n_fail++; $display("FAIL dir_overflow w=%0d got=%b exp=%b", widths[k], o, e[SEC_W]); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dir_busy_after w=%0d got=%b exp=0", widths[k], busy); end
            last_sec = e[SEC_W-1:0];
            last_ovf = e[SEC_W];
        end
    endtask

    task automatic test_armed_while_high();
        int               vcnt;
        int               extra = 0;
        logic [SEC_W-1:0] s;
        logic             o;
        logic [SEC_W:0]   e;
        sig_in = 1'b1;
        repeat (5) tick();
        do_arm();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL high_busy_armed got=%b exp=1", busy); end
        repeat (30) tick();
        sig_in = 1'b0;
        repeat (6) begin
            tick();
            if (valid) extra++;
        end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL high_busy_wait_rise got=%b exp=1", busy); end
        run_pulse(20, vcnt, s, o);
        e = model(20);
        n_checks++; if (vcnt + extra !== 1) begin n_fail++; $display("FAIL high_valid_count got=%0d exp=1", vcnt + extra); end
        n_checks++; if (s !== e[SEC_W-1:0]) begin n_fail++; $display("FAIL high_seconds got=%0d exp=%0d", s, e[SEC_W-1:0]); end
        last_sec = e[SEC_W-1:0];
        last_ovf = e[SEC_W];
    endtask

    task automatic test_no_arm();
        int               vcnt;
        logic [SEC_W-1:0] s;
        logic             o;
        run_pulse(30, vcnt, s, o);
        n_checks++; if (vcnt !== 0) begin n_fail++; $display("FAIL noarm_valid_count got=%0d exp=0", vcnt); end
        n_checks++; if (seconds !== last_sec) begin n_fail++; $display("FAIL noarm_seconds got=%0d exp=%0d", seconds, last_sec); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL noarm_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int               seen = 0;
        int               vcnt;
        logic [SEC_W-1:0] s;
        logic             o;
        logic [SEC_W:0]   e1;
        logic [SEC_W:0]   e2;
        int               h1;
        int               h2;
        h1 = $urandom_range(40, 90);
        h2 = $urandom_range(100, 200);
        e1 = model(h1);
        e2 = model(h2);
        do_arm();
        tick();
        sig_in = 1'b1;
        repeat (h1) tick();
        sig_in = 1'b0;
        for (int i = 0; i < 8 && seen == 0; i++) begin
            tick();
            if (valid) seen = 1;
        end
        n_checks++; if (seen !== 1) begin n_fail++; $display("FAIL b2b_first_valid got=%0d exp=1", seen); end
        n_checks++; if (seconds !== e1[SEC_W-1:0]) begin n_fail++; $display("FAIL b2b_first_seconds h=%0d got=%0d exp=%0d", h1, seconds, e1[SEC_W-1:0]); end
        // arm during the valid cycle
        do_arm();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_rearm_busy got=%b exp=1", busy); end
        n_checks++; if (seconds !== e1[SEC_W-1:0]) begin n_fail++; $display("FAIL b2b_old_held got=%0d exp=%0d", seconds, e1[SEC_W-1:0]); end
        tick();
        run_pulse(h2, vcnt, s, o);
        n_checks++; if (vcnt !== 1) begin n_fail++; $display("FAIL b2b_second_count got=%0d exp=1", vcnt); end
        n_checks++; if (s !== e2[SEC_W-1:0]) begin n_fail++; $display("FAIL b2b_second_seconds h=%0d got=%0d exp=%0d", h2, s, e2[SEC_W-1:0]); end
        last_sec = e2[SEC_W-1:0];
        last_ovf = e2[SEC_W];
    endtask

    task automatic test_reset_mid();
        int vcnt = 0;
        do_arm();
        tick();
        sig_in = 1'b1;
        repeat (15) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        n_checks++; if (seconds !== '0) begin n_fail++; $display("FAIL rstmid_seconds got=%0d exp=0", seconds); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_overflow got=%b exp=0", overflow); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", valid); end
        tick();
        rst = 1'b0;
        repeat (5) tick();
        sig_in = 1'b0;
        repeat (15) begin
            tick();
            if (valid) vcnt++;
        end
        n_checks++; if (vcnt !== 0) begin n_fail++; $display("FAIL rstmid_no_valid got=%0d exp=0", vcnt); end
        last_sec = '0;
        last_ovf = 1'b0;
    endtask

    task automatic test_random();
        int               h;
        int               vcnt;
        logic [SEC_W-1:0] s;
        logic             o;
        logic [SEC_W:0]   e;
        for (int k = 0; k < 14; k++) begin
            h = (k < 4) ? $urandom_range(1, CPS - 1) : $urandom_range(1, 360);
            e = model(h);
            do_arm();
            repeat ($urandom_range(0, 4)) tick();
            if ($urandom_range(0, 1) == 1) do_arm();   // ignored while busy
            run_pulse(h, vcnt, s, o);
            n_checks++; if (vcnt !== 1) begin n_fail++; $display("FAIL rnd_valid_count h=%0d got=%0d exp=1", h, vcnt); end
            n_checks++; if ({o, s} !== e) begin n_fail++; $display("FAIL rnd_result h=%0d got=%b/%0d exp=%b/%0d", h, o, s, e[SEC_W], e[SEC_W-1:0]); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_busy_after h=%0d got=%b exp=0", h, busy); end
            last_sec = e[SEC_W-1:0];
            last_ovf = e[SEC_W];
            repeat ($urandom_range(1, 5)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_armed_while_high();
        test_no_arm();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_no_arm();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
